// File: rtl/pc_gen.sv
// Program-counter generator: fetch address with a valid/ready handshake toward
// instruction memory, plus redirect, trap/mret, stall and halt handling.
module pc_gen #(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic            halt_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_addr_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] epc_o,
  output logic            misaligned_o,
  output logic            halted_o
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] epc, epc_nxt;
  logic            mis_q, mis_nxt;
  logic            fire;

  assign fetch_valid_o = (state == RUN);
  assign halted_o      = (state == HALT);
  assign fire          = fetch_valid_o & fetch_ready_i & ~stall_i;
  assign fetch_addr_o  = pc;
  assign pc_plus4_o    = pc + XLEN'(4);
  assign epc_o         = epc;
  assign misaligned_o  = mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      epc   <= '0;
      mis_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      epc   <= epc_nxt;
      mis_q <= mis_nxt;
    end
  end

  // Jumps ignore stall/ready: the in-flight fetch is simply dropped.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc;
    mis_nxt   = 1'b0;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (trap_i) begin
          pc_nxt  = TRAP_VECTOR;
          epc_nxt = pc;
        end else if (mret_i) begin
          pc_nxt = epc;
        end else if (redirect_i) begin
          if (redirect_target_i[1:0] != 2'b00) begin
            pc_nxt  = TRAP_VECTOR;
            epc_nxt = redirect_target_i;
            mis_nxt = 1'b1;
          end else begin
            pc_nxt = redirect_target_i;
          end
        end else if (halt_i) begin
          state_nxt = HALT;
        end else if (fire) begin
          pc_nxt = pc + XLEN'(4);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit and an 8-bit (wrapping) instance share
// stimulus; a behavioural model pushes expected outputs, a monitor compares.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, redirect, trap, mret, halt, ready;
  logic [31:0] tgt;

  logic [31:0] addr0, p40, epc0;
  logic        v0, mis0, h0;
  logic [7:0]  addr1, p41, epc1;
  logic        v1, mis1, h1;

  pc_gen dut0 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_target_i(tgt), .trap_i(trap), .mret_i(mret), .halt_i(halt),
    .fetch_ready_i(ready), .fetch_valid_o(v0), .fetch_addr_o(addr0),
    .pc_plus4_o(p40), .epc_o(epc0), .misaligned_o(mis0), .halted_o(h0)
  );

  pc_gen #(.XLEN(8), .RESET_VECTOR(8'hF8)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
    .redirect_target_i(tgt[7:0]), .trap_i(trap), .mret_i(mret), .halt_i(halt),
    .fetch_ready_i(ready), .fetch_valid_o(v1), .fetch_addr_o(addr1),
    .pc_plus4_o(p41), .epc_o(epc1), .misaligned_o(mis1), .halted_o(h1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] p4;
    logic [31:0] epc;
    logic        valid;
    logic        mis;
    logic        halted;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  // Reference model: PC as a number modulo 2^XLEN, mode as two flags.
  logic [31:0] m_pc[2], m_epc[2];
  bit          m_boot[2], m_halt[2], m_mis[2];
  logic [31:0] mask[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] rv[2]   = '{32'h0000_0000, 32'h0000_00F8};
  logic [31:0] tv[2]   = '{32'h0000_0100, 32'h0000_0000};

  function automatic void m_reset(int k);
    m_pc[k] = rv[k]; m_epc[k] = 32'd0;
    m_boot[k] = 1'b1; m_halt[k] = 1'b0; m_mis[k] = 1'b0;
  endfunction

  function automatic exp_t m_expect(int k);
    exp_t e;
    e.addr = m_pc[k];
    e.p4 = (m_pc[k] + 32'd4) & mask[k];
    e.epc = m_epc[k];
    e.valid = !m_boot[k] && !m_halt[k];
    e.mis = m_mis[k];
    e.halted = m_halt[k];
    return e;
  endfunction

  function automatic void m_advance(int k);
    logic [31:0] t;
    t = tgt & mask[k];
    m_mis[k] = 1'b0;
    if (m_boot[k]) m_boot[k] = 1'b0;
    else if (!m_halt[k]) begin
      if (trap) begin
        m_epc[k] = m_pc[k]; m_pc[k] = tv[k];
      end else if (mret) m_pc[k] = m_epc[k];
      else if (redirect) begin
        if (t % 4 != 0) begin
          m_epc[k] = t; m_pc[k] = tv[k]; m_mis[k] = 1'b1;
        end else m_pc[k] = t;
      end else if (halt) m_halt[k] = 1'b1;
      else if (ready && !stall) m_pc[k] = (m_pc[k] + 32'd4) & mask[k];
    end
  endfunction

  task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] t,
                      input bit tr, input bit mr, input bit hl, input bit rdy);
    @(posedge clk);
    #1;
    rst_n = r; stall = s; redirect = rd; tgt = t;
    trap = tr; mret = mr; halt = hl; ready = rdy;
    for (int k = 0; k < 2; k++) if (!rst_n) m_reset(k);
    q0.push_back(m_expect(0));
    q1.push_back(m_expect(1));
    for (int k = 0; k < 2; k++) if (rst_n) m_advance(k);
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("addr32", addr0, e.addr);
      chk("plus4_32", p40, e.p4);
      chk("epc32", epc0, e.epc);
      chk("valid32", {31'd0, v0}, {31'd0, e.valid});
      chk("mis32", {31'd0, mis0}, {31'd0, e.mis});
      chk("halted32", {31'd0, h0}, {31'd0, e.halted});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("addr8", {24'd0, addr1}, e.addr);
      chk("plus4_8", {24'd0, p41}, e.p4);
      chk("epc8", {24'd0, epc1}, e.epc);
      chk("valid8", {31'd0, v1}, {31'd0, e.valid});
      chk("mis8", {31'd0, mis1}, {31'd0, e.mis});
      chk("halted8", {31'd0, h1}, {31'd0, e.halted});
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; tgt = '0;
    trap = 1'b0; mret = 1'b0; halt = 1'b0; ready = 1'b0;
    for (int k = 0; k < 2; k++) m_reset(k);

    // reset, boot, run 0,4,8 (8-bit instance: F8,FC,00)
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // backpressure and stall at PC=8
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // redirect under stall at 0x10, then misaligned target
    step(1, 1, 1, 32'h40, 0, 0, 0, 1);
    step(1, 0, 1, 32'h42, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // trap at 0x24, mret, trap+mret together
    step(1, 0, 1, 32'h24, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // halt at 0x30, redirects ignored
    step(1, 0, 1, 32'h30, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 1, 32'h80, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // asynchronous reset mid-cycle with a redirect pending
    step(0, 0, 1, 32'h60, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, t, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 3) != 0);
    end

    repeat (3) @(negedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d expected=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
